// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between CPU and peripheral.
// Every access runs IDLE -> ACCESS -> WAIT -> RESP, with a one-cycle ready pulse in RESP.
module mem_arbiter #(
   parameter int DATA_W = 22,
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              per_req,
   input  logic              per_we,
   input  logic [ADDR_W-1:0] per_addr,
   input  logic [DATA_W-1:0] per_wdata,
   output logic              per_ready,
   output logic [DATA_W-1:0] per_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t state_q, state_d;
   logic grant_q, grant_d;
   logic last_q, last_d;
   logic cpu_ready_q, cpu_ready_d;
   logic per_ready_q, per_ready_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] per_rdata_q, per_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic mem_we_q, mem_we_d;
   logic win_per;

   // grant/last encoding: 1 = peripheral; on a tie the port not served last wins
   assign win_per = per_req & (~cpu_req | ~last_q);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      cpu_ready_d = 1'b0;
      per_ready_d = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      per_rdata_d = per_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu_req | per_req) begin
               grant_d     = win_per;
               last_d      = win_per;
               mem_addr_d  = win_per ? per_addr  : cpu_addr;
               mem_wdata_d = win_per ? per_wdata : cpu_wdata;
               mem_we_d    = win_per ? per_we    : cpu_we;
               state_d     = ACCESS;
            end
         end
         ACCESS: state_d = WAIT;
         WAIT: begin
            if (grant_q) begin
               per_rdata_d = mem_rdata;
               per_ready_d = 1'b1;
            end else begin
               cpu_rdata_d = mem_rdata;
               cpu_ready_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         cpu_ready_q <= 1'b0;
         per_ready_q <= 1'b0;
         cpu_rdata_q <= '0;
         per_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         cpu_ready_q <= cpu_ready_d;
         per_ready_q <= per_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         per_rdata_q <= per_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign cpu_ready = cpu_ready_q;
   assign per_ready = per_ready_q;
   assign cpu_rdata = cpu_rdata_q;
   assign per_rdata = per_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign cpu_stall = cpu_req & ~cpu_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions plus
// contention, mid-transaction reset and idle-hold sequences.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [21:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_ready, cpu_stall;
   logic [21:0] cpu_rdata;
   logic        per_req = 1'b0, per_we = 1'b0;
   logic [21:0] per_addr = '0, per_wdata = '0;
   logic        per_ready;
   logic [21:0] per_rdata;
   logic [21:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   int checks = 0;
   int errors = 0;
   logic [21:0] exp_cpu_rd, exp_per_rd;
   logic [21:0] ram [256];

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_W(22), .ADDR_W(22)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall),
      .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
      .per_wdata(per_wdata), .per_ready(per_ready), .per_rdata(per_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   // read-first synchronous RAM, reloaded while rst is high
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
         ram[8'h10] <= 22'h2ABCDE;
         ram[8'h00] <= 22'h000001;
         ram[8'hFF] <= 22'h123456;
         mem_rdata  <= '0;
      end else begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   typedef struct {
      logic        port;
      logic        we;
      logic [21:0] addr;
      logic [21:0] wdata;
      logic [21:0] exp_rd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Called just after a negedge in IDLE; returns just after a negedge.
   task automatic run_txn(input vec_t v);
      int lat;
      int wecnt;
      logic [21:0] other;
      if (!v.port) begin
         cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
      end else begin
         per_we = v.we; per_addr = v.addr; per_wdata = v.wdata; per_req = 1'b1;
      end
      lat = -1;
      wecnt = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (mem_we) wecnt++;
         if (c == 1) chk("access_addr", 32'(mem_addr), 32'(v.addr));
         if (!v.port && c == 0) chk("stall_c0", 32'(cpu_stall), 32'd1);
         if ((!v.port && cpu_ready) || (v.port && per_ready)) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'd3);
      chk("we_cycles", 32'(wecnt), 32'(v.we));
      if (!v.port) begin
         chk("stall_ready", 32'(cpu_stall), 32'd0);
         chk("other_ready", 32'(per_ready), 32'd0);
         chk("cpu_rdata", 32'(cpu_rdata), 32'(v.exp_rd));
         other = exp_per_rd;
         chk("per_rdata_kept", 32'(per_rdata), 32'(other));
         exp_cpu_rd = v.exp_rd;
      end else begin
         chk("other_ready", 32'(cpu_ready), 32'd0);
         chk("per_rdata", 32'(per_rdata), 32'(v.exp_rd));
         other = exp_cpu_rd;
         chk("cpu_rdata_kept", 32'(cpu_rdata), 32'(other));
         exp_per_rd = v.exp_rd;
      end
      cpu_req = 1'b0;
      per_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_cpu_rd = '0;
      exp_per_rd = '0;
   endtask

   vec_t vecs [9];
   int   cpu_rc [2];
   int   per_rc [2];
   int   nc, np, bad;
   logic [21:0] per_rd_c6;
   logic [21:0] cpu_rd_hist [2];
   logic [21:0] per_rd_hist [2];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 22'h000010, 22'h0,      22'h2ABCDE};
      vecs[1] = '{1'b1, 1'b1, 22'h000020, 22'h155555, 22'h000000};
      vecs[2] = '{1'b0, 1'b0, 22'h000020, 22'h0,      22'h155555};
      vecs[3] = '{1'b1, 1'b0, 22'h000010, 22'h0,      22'h2ABCDE};
      vecs[4] = '{1'b0, 1'b1, 22'h000030, 22'h3FFFFF, 22'h000000};
      vecs[5] = '{1'b1, 1'b0, 22'h000030, 22'h0,      22'h3FFFFF};
      vecs[6] = '{1'b0, 1'b0, 22'h000000, 22'h0,      22'h000001};
      vecs[7] = '{1'b1, 1'b1, 22'h3FFFFF, 22'h000000, 22'h123456};
      vecs[8] = '{1'b0, 1'b0, 22'h3FFFFF, 22'h0,      22'h000000};

      do_reset();
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_per_ready", 32'(per_ready), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_per_rdata", 32'(per_rdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Contention from reset: CPU, PER, CPU, PER
      do_reset();
      nc = 0; np = 0;
      per_rd_c6 = '1;
      cpu_we = 1'b0; cpu_addr = 22'h000010; cpu_req = 1'b1;
      per_we = 1'b0; per_addr = 22'h000000; per_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (c == 6) per_rd_c6 = per_rdata;
         if (cpu_ready && nc < 2) begin
            cpu_rc[nc] = c; cpu_rd_hist[nc] = cpu_rdata; nc++;
            cpu_addr = 22'h000000;
            if (nc == 2) cpu_req = 1'b0;
         end
         if (per_ready && np < 2) begin
            per_rc[np] = c; per_rd_hist[np] = per_rdata; np++;
            per_addr = 22'h000010;
            if (np == 2) per_req = 1'b0;
         end
         @(negedge clk);
      end
      chk("cont_cpu_cnt", 32'(nc), 32'd2);
      chk("cont_per_cnt", 32'(np), 32'd2);
      if (nc == 2 && np == 2) begin
         chk("cont_cpu_t0", 32'(cpu_rc[0]), 32'd3);
         chk("cont_per_t0", 32'(per_rc[0]), 32'd7);
         chk("cont_cpu_t1", 32'(cpu_rc[1]), 32'd11);
         chk("cont_per_t1", 32'(per_rc[1]), 32'd15);
         chk("cont_cpu_rd0", 32'(cpu_rd_hist[0]), 32'h2ABCDE);
         chk("cont_per_rd0", 32'(per_rd_hist[0]), 32'h000001);
         chk("cont_cpu_rd1", 32'(cpu_rd_hist[1]), 32'h000001);
         chk("cont_per_rd1", 32'(per_rd_hist[1]), 32'h2ABCDE);
      end
      chk("cont_per_rd_c6", 32'(per_rd_c6), 32'd0);
      exp_cpu_rd = 22'h000001;
      exp_per_rd = 22'h2ABCDE;

      // Reset during WAIT of a CPU read
      cpu_we = 1'b0; cpu_addr = 22'h000010; cpu_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("mid_rst_per_rdata", 32'(per_rdata), 32'd0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_cpu_rd = '0;
      exp_per_rd = '0;
      run_txn(vecs[0]);

      // Idle hold
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (mem_we || cpu_ready || per_ready) bad++;
         @(negedge clk);
      end
      chk("idle_quiet", 32'(bad), 32'd0);
      run_txn(vecs[3]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous-read, single-port 22-bit data memory between the processor data path (load/store and PC-from-memory reads) and a peripheral port (image loader / display reader).
- Arbitrates using round-robin and sequences each access through a fixed 4-cycle transaction.
- Returns read data with a one-cycle ready pulse.
- Drives cpu_stall so the processor can freeze its PC flip-flop enable and register-file writes while its access is pending.

Parameters:
- DATA_W, 22, width of data words and of memory read/write data.
- ADDR_W, 22, width of the byte address presented to memory.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  processor requests an access; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  processor access address.
- cpu_wdata  in  DATA_W  processor write data.
- cpu_ready  out  1  one-cycle pulse: processor transaction complete.
- cpu_rdata  out  DATA_W  processor read data; valid while cpu_ready=1, held afterwards.
- cpu_stall  out  1  = cpu_req & ~cpu_ready (combinational).
- per_req  in  1  peripheral requests an access; held until per_ready.
- per_we  in  1  1 = write, 0 = read.
- per_addr  in  ADDR_W  peripheral access address.
- per_wdata  in  DATA_W  peripheral write data.
- per_ready  out  1  one-cycle pulse: peripheral transaction complete.
- per_rdata  out  DATA_W  peripheral read data; valid while per_ready=1, held afterwards.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_we  out  1  memory write enable (registered).
- mem_rdata  in  DATA_W  memory read data; valid the cycle after the address edge.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; last_grant=PER, so the CPU wins the first tie. All of the following are cleared to 0: cpu_ready, per_ready, cpu_rdata, per_rdata, mem_addr, mem_wdata, mem_we, grant. An in-flight transaction is abandoned and not retried; the requester must re-request.
- FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE, which holds while no request is present.
- IDLE:
  - Requests are sampled only in this state.
  - Only one requester active: that requester wins.
  - Both active: the requester other than last_grant wins.
  - On the edge leaving IDLE, register grant, last_grant, and the winner's addr/wdata/we into mem_addr/mem_wdata/mem_we.
- ACCESS: mem_* outputs are valid. mem_we=1 only in this state, and only for a write. The RAM samples the address on the closing edge.
- WAIT:
  - mem_we=0; mem_addr is held.
  - mem_rdata is valid.
  - On the closing edge, mem_rdata is captured into the granted port's rdata register and that port's ready is set.
  - For writes the captured value is don't-care but is still updated.
- RESP:
  - The granted ready=1 for exactly this cycle; the other port's ready stays 0.
  - Requests are not sampled.
  - On the closing edge, ready clears and the FSM returns to IDLE.
- Latency: req seen in IDLE at cycle 0 -> ready=1 at cycle 3. Back-to-back throughput is one transaction per 4 cycles.
- Requester rule: signals stay stable from req until ready. A requester with no further work deasserts req on the edge following its ready. If req is still high in the following IDLE, that is a new transaction.
- Fairness: with both ports requesting continuously, grants strictly alternate. Neither port waits more than one foreign transaction (4 cycles) before its own grant.
- The non-granted port's rdata register is never modified.
- Address and data pass through unmodified; there is no width conversion and no alignment checking.

Test Plan:
- Single CPU read: preload mem[0x000010]=0x2ABCDE; cpu_req=1, cpu_we=0, cpu_addr=0x000010 -> mem_we=0 throughout; cpu_ready=1 exactly at cycle 3; cpu_rdata=0x2ABCDE; cpu_stall=1 in cycles 0-2 and 0 in cycle 3.
- Peripheral write then CPU read of same address: per write 0x155555 to 0x000020 -> mem_we=1 for exactly one cycle (ACCESS) with mem_addr=0x000020; then CPU read of 0x000020 -> cpu_rdata=0x155555.
- Simultaneous requests after reset: both req=1 at cycle 0 -> CPU granted first (cpu_ready at cycle 3), per_ready at cycle 7; per_rdata unchanged until cycle 7.
- Continuous contention over 4 transactions: both ports hold req (new addr after each ready) -> grant order CPU, PER, CPU, PER; ready pulses at cycles 3, 7, 11, 15.
- Reset mid-transaction: assert rst during WAIT of a CPU read -> all outputs 0 immediately (asynchronous); after release with cpu_req=1, a full 4-cycle transaction completes correctly.
- Idle hold: no requests for 10 cycles -> state stays IDLE, mem_we=0, no ready pulses.
